board_reader: RTL and testbench
===============================

BOARD_READER -- requirements
Module: board_reader

Interface
REQ-001 Parameter WIDTH, default 11: cells per board row, minimum 2.
REQ-002 Parameter ROWS, default 8: rows per board, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one full board scan; sampled only in IDLE.
REQ-006 row_addr  output  $clog2(ROWS)  row select to board storage.
REQ-007 row_data  input  WIDTH  row contents; combinational from row_addr, valid in the same cycle.
REQ-008 cell_out  output  1  current cell value.
REQ-009 cell_x  output  $clog2(WIDTH)  column of cell_out; bit 0 of the row is column 0.
REQ-010 cell_y  output  $clog2(ROWS)  row of cell_out.
REQ-011 cell_valid  output  1  cell_out, cell_x, cell_y and cell_last are valid.
REQ-012 cell_ready  input  1  consumer accepts the cell.
REQ-013 cell_last  output  1  high with the final cell (x=WIDTH-1, y=ROWS-1).
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the last cell is accepted.

Function
REQ-016 States SHALL be IDLE, FETCH, STREAM, DONE.
REQ-017 IDLE: start=1 -> FETCH with y=0; start=0 -> stay in IDLE.
REQ-018 FETCH: row_addr=y; the block captures row_data into a WIDTH-bit shift register, sets x=0 and moves to STREAM. FETCH lasts exactly one cycle.
REQ-019 STREAM: cell_valid=1, cell_out=shift register bit 0, cell_x=x, cell_y=y.
REQ-020 Transfer occurs when cell_valid and cell_ready are both high; on a transfer the shift register shifts right by 1 and x increments.
REQ-021 When cell_valid=1 and cell_ready=0, cell_out, cell_x, cell_y and cell_last SHALL hold stable.
REQ-022 Transfer at x=WIDTH-1 with y<ROWS-1 -> FETCH with y+1.
REQ-023 Transfer at x=WIDTH-1 with y=ROWS-1 -> DONE.
REQ-024 Each row costs 1 FETCH cycle plus WIDTH transfer cycles.
REQ-025 With cell_ready held high, a full scan from start to the done pulse SHALL take exactly ROWS*(WIDTH+1)+1 cycles.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 cell_valid SHALL be 0 in IDLE, FETCH and DONE.
REQ-028 start asserted while busy=1 SHALL be ignored and not queued.
REQ-029 row_addr SHALL equal y in every state; it is 0 in IDLE.
REQ-030 x and y SHALL never exceed WIDTH-1 and ROWS-1; no wrap-around past the last cell.

Reset
REQ-031 reset=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, x=0, y=0, shift register=0, and every output to 0.
REQ-032 Reset asserted mid-scan SHALL abort the scan with no done pulse.
REQ-033 The first start after reset is released SHALL begin a fresh scan at row 0.

Configuration
REQ-034 Macro BOARD_READER_LIVE_COUNT_EN SHALL control the live-cell counter feature.
REQ-035 With the macro defined: add output live_count, width $clog2(WIDTH*ROWS+1).
  - Cleared on entry to FETCH for y=0.
  - Incremented on each transfer with cell_out=1.
  - Holds its value from DONE until the next start.
  - Reset value 0.
REQ-036 Without the macro: no live_count port and no counter logic; all other behaviour is identical.

Verification
REQ-037 Reset check: reset=0 at time 0, check before any clock edge -> all outputs 0, busy=0.
REQ-038 Full scan, cell_ready=1, WIDTH=11, ROWS=8, row 0 = 11'b00000001100, other rows 0:
  - cells (2,0) and (3,0) are 1, all others 0.
  - cell_last high only at (10,7).
  - done pulses exactly 97 cycles after start.
REQ-039 Backpressure: cell_ready=0 for 5 cycles at (4,2) -> outputs hold (4,2) stable; the scan resumes and completes with no cell lost or duplicated.
REQ-040 start pulsed at (6,3) mid-scan -> scan unaffected, exactly one done pulse, then IDLE.
REQ-041 reset=0 at (5,5) -> immediate IDLE, no done pulse; the next start scans from (0,0).
REQ-042 With BOARD_READER_LIVE_COUNT_EN, board holding 13 live cells -> live_count=13 at done, and it holds 13 until the next start.

Source files
------------

// File: rtl/board_reader.sv
// board_reader: scans a ROWS x WIDTH board one row at a time and streams its
// cells out over a valid/ready handshake, row 0 first, column 0 first.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-low reset
//   start      - request one full board scan (sampled only while idle)
//   row_addr   - row select to board storage (always equals the current row)
//   row_data   - row contents, combinational from row_addr
//   cell_out   - current cell value
//   cell_x     - column of cell_out (bit 0 of the row is column 0)
//   cell_y     - row of cell_out
//   cell_valid - cell_out/cell_x/cell_y/cell_last are valid
//   cell_ready - consumer accepts the cell
//   cell_last  - high with the final cell (WIDTH-1, ROWS-1)
//   busy       - high whenever a scan is in progress
//   done       - one-cycle pulse after the last cell is accepted
//   live_count - number of 1-cells streamed in the current/last scan
//                (only when BOARD_READER_LIVE_COUNT_EN is defined)
//
// Optional feature macro: BOARD_READER_LIVE_COUNT_EN
module board_reader #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned ROWS  = 8,
    localparam int unsigned XW   = $clog2(WIDTH),
    localparam int unsigned YW   = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [YW-1:0]    row_addr,
    input  logic [WIDTH-1:0] row_data,
    output logic             cell_out,
    output logic [XW-1:0]    cell_x,
    output logic [YW-1:0]    cell_y,
    output logic             cell_valid,
    input  logic             cell_ready,
    output logic             cell_last,
    output logic             busy,
    output logic             done
`ifdef BOARD_READER_LIVE_COUNT_EN
    ,
    output logic [$clog2(WIDTH*ROWS+1)-1:0] live_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             cell_valid_q, cell_valid_d;
    logic             cell_last_q, cell_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic xfer_c;
    logic x_end_c;
    logic y_end_c;

    assign xfer_c  = cell_valid_q && cell_ready;
    assign x_end_c = (x_q == XW'(WIDTH - 1));
    assign y_end_c = (y_q == YW'(ROWS - 1));

    // Next-state, counters, shift register and registered-output decode
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sr_d    = sr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            FETCH: begin
                sr_d    = row_data;
                x_d     = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (xfer_c) begin
                    sr_d = sr_q >> 1;
                    if (!x_end_c) begin
                        x_d = x_q + XW'(1);
                    end else if (!y_end_c) begin
                        // Next row; x restarts in FETCH
                        x_d     = '0;
                        y_d     = y_q + YW'(1);
                        state_d = FETCH;
                    end else begin
                        // Final cell: x/y park at the last position
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                x_d     = '0;
                y_d     = '0;
                sr_d    = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cell_valid_d = (state_d == STREAM);
        cell_last_d  = (state_d == STREAM) && (x_d == XW'(WIDTH - 1))
                       && (y_d == YW'(ROWS - 1));
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            sr_q         <= '0;
            cell_valid_q <= 1'b0;
            cell_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sr_q         <= sr_d;
            cell_valid_q <= cell_valid_d;
            cell_last_q  <= cell_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign row_addr   = y_q;
    assign cell_out   = sr_q[0];
    assign cell_x     = x_q;
    assign cell_y     = y_q;
    assign cell_valid = cell_valid_q;
    assign cell_last  = cell_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef BOARD_READER_LIVE_COUNT_EN
    localparam int unsigned LCW = $clog2(WIDTH*ROWS+1);

    logic [LCW-1:0] lc_q, lc_d;

    // Live-cell counter: cleared when a scan starts, held after it ends
    always_comb begin
        lc_d = lc_q;
        if ((state_q == IDLE) && start) begin
            lc_d = '0;
        end else if (xfer_c && sr_q[0]) begin
            lc_d = lc_q + LCW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lc_q <= '0;
        end else begin
            lc_q <= lc_d;
        end
    end

    assign live_count = lc_q;
`endif

endmodule

// File: tb/tb_board_reader.sv
// Self-checking bench for board_reader (WIDTH=11, ROWS=8).
module tb_board_reader;

    localparam int unsigned WIDTH = 11;
    localparam int unsigned ROWS  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        row_addr;
    logic [WIDTH-1:0]  row_data;
    logic              cell_out;
    logic [3:0]        cell_x;
    logic [2:0]        cell_y;
    logic              cell_valid;
    logic              cell_ready = 1'b0;
    logic              cell_last;
    logic              busy;
    logic              done;
`ifdef BOARD_READER_LIVE_COUNT_EN
    logic [6:0]        live_count;
`endif

    logic [WIDTH-1:0]  mem [ROWS];

    assign row_data = mem[row_addr];

    board_reader #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .row_addr   (row_addr),
        .row_data   (row_data),
        .cell_out   (cell_out),
        .cell_x     (cell_x),
        .cell_y     (cell_y),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready),
        .cell_last  (cell_last),
        .busy       (busy),
        .done       (done)
`ifdef BOARD_READER_LIVE_COUNT_EN
        ,
        .live_count (live_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] x;
        logic [2:0] y;
        logic       v;
        logic       last;
    } cell_t;

    // mode: 0 ready=1, 1 random ready, 2 stall 5 at (4,2),
    //       3 start pulse at (6,3), 4 reset at (5,5)
    typedef struct {
        logic [WIDTH-1:0] row0;
        logic [WIDTH-1:0] mid;
        logic [WIDTH-1:0] rlast;
        int               mode;
        int               exp_ones;
        int               exp_cycles;
    } vec_t;

    vec_t  vecs [8];
    cell_t q [$];
    int    checks = 0;
    int    errors = 0;
    int    ones_seen = 0;

    logic  prev_valid = 1'b0;
    logic  prev_ready = 1'b0;
    logic [8:0] prev_cell = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: pop one expected cell per accepted transfer; check hold on stall
    always @(negedge clk) begin
        if (reset) begin
            if (prev_valid && !prev_ready) begin
                chk("hold", 32'({cell_valid, cell_out, cell_x, cell_y, cell_last}),
                    32'({1'b1, prev_cell}));
            end
            if (cell_valid && cell_ready) begin
                chk("queue_nonempty", 32'(q.size() != 0), 32'(1));
                if (q.size() != 0) begin
                    cell_t e;
                    e = q.pop_front();
                    chk("cell", 32'({cell_x, cell_y, cell_out, cell_last}), 32'(e));
                    chk("row_addr", 32'(row_addr), 32'(e.y));
                    if (cell_out) ones_seen++;
                end
            end
        end
        prev_valid <= cell_valid;
        prev_ready <= cell_ready;
        prev_cell  <= {cell_out, cell_x, cell_y, cell_last};
    end

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int stall_left;
        int extra_done;
        bit got_done;
        bit pulsed;
        bit aborted;

        mem[0] = v.row0;
        for (int r = 1; r < ROWS - 1; r++) mem[r] = v.mid;
        mem[ROWS-1] = v.rlast;
        q.delete();
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < WIDTH; x++) begin
                cell_t c;
                c.x    = 4'(x);
                c.y    = 3'(y);
                c.v    = mem[y][x];
                c.last = (x == WIDTH - 1) && (y == ROWS - 1);
                q.push_back(c);
            end
        end
        ones_seen  = 0;
        stall_left = 5;
        pulsed     = 0;
        aborted    = 0;
        got_done   = 0;

        start      = 1'b1;
        cell_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        chk("busy_after_start", 32'(busy), 32'(1));

        while (cyc < 400 && !got_done && !aborted) begin
            cell_ready = 1'b1;
            start      = 1'b0;
            if (v.mode == 1) cell_ready = ($urandom_range(0, 3) != 0);
            if (v.mode == 2 && cell_valid && cell_x == 4'd4 && cell_y == 3'd2 && stall_left > 0) begin
                cell_ready = 1'b0;
                stall_left--;
            end
            if (v.mode == 3 && cell_valid && cell_x == 4'd6 && cell_y == 3'd3 && !pulsed) begin
                start  = 1'b1;
                pulsed = 1;
            end
            if (v.mode == 4 && cell_valid && cell_x == 4'd5 && cell_y == 3'd5) begin
                reset   = 1'b0;
                aborted = 1;
            end
            if (!aborted) begin
                @(posedge clk);
                #1;
                cyc++;
                if (done) got_done = 1;
            end
        end
        start = 1'b0;

        if (aborted) begin
            #1;
            chk("abort_outputs", 32'({busy, done, cell_valid, cell_out, cell_x, cell_y, cell_last, row_addr}), 32'(0));
`ifdef BOARD_READER_LIVE_COUNT_EN
            chk("abort_live_count", 32'(live_count), 32'(0));
`endif
            @(posedge clk);
            @(posedge clk);
            #1;
            reset = 1'b1;
            extra_done = 0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk);
                #1;
                if (done) extra_done++;
            end
            chk("abort_no_done", 32'(extra_done), 32'(0));
            chk("abort_idle", 32'(busy), 32'(0));
            q.delete();
        end else begin
            chk($sformatf("done_seen_v%0d", idx), 32'(got_done), 32'(1));
            if (v.exp_cycles != 0) chk($sformatf("latency_v%0d", idx), 32'(cyc), 32'(v.exp_cycles));
            chk($sformatf("cells_left_v%0d", idx), 32'(q.size()), 32'(0));
            chk($sformatf("ones_v%0d", idx), 32'(ones_seen), 32'(v.exp_ones));
            chk("valid_at_done", 32'(cell_valid), 32'(0));
`ifdef BOARD_READER_LIVE_COUNT_EN
            chk("live_count_at_done", 32'(live_count), 32'(v.exp_ones));
`endif
            @(posedge clk);
            #1;
            chk("done_one_cycle", 32'({done, busy}), 32'(0));
            extra_done = 0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk);
                #1;
                if (done) extra_done++;
            end
            chk("no_extra_done", 32'(extra_done), 32'(0));
            chk("idle_after", 32'({busy, cell_valid, row_addr}), 32'(0));
`ifdef BOARD_READER_LIVE_COUNT_EN
            chk("live_count_hold", 32'(live_count), 32'(v.exp_ones));
`endif
        end
    endtask

    initial begin
        vecs[0] = '{11'b00000001100, 11'h000, 11'h000, 0,  2,  97};
        vecs[1] = '{11'h7FF,         11'h001, 11'h001, 0, 18,  97};
        vecs[2] = '{11'h555,         11'h2AA, 11'h2AA, 1, 41,   0};
        vecs[3] = '{11'h000,         11'h400, 11'h400, 2,  7, 102};
        vecs[4] = '{11'h003,         11'h180, 11'h180, 3, 16,  97};
        vecs[5] = '{11'h0F0,         11'h000, 11'h000, 4,  0,   0};
        vecs[6] = '{11'h00C,         11'h000, 11'h000, 0,  2,  97};
        vecs[7] = '{11'h7FF,         11'h000, 11'h005, 0, 13,  97};

        for (int r = 0; r < ROWS; r++) mem[r] = '0;

        // Asynchronous reset, checked before the first clock edge
        reset = 1'b0;
        #1;
        chk("reset_outputs", 32'({busy, done, cell_valid, cell_out, cell_x, cell_y, cell_last, row_addr}), 32'(0));
`ifdef BOARD_READER_LIVE_COUNT_EN
        chk("reset_live_count", 32'(live_count), 32'(0));
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_no_start", 32'({busy, done, cell_valid}), 32'(0));

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
